instruction_fetch: RTL and testbench

Fetch stage of the MIPS core. It owns the program counter and drives the address into the synchronous-read instruction memory, which returns data one cycle after the address is sampled. It delivers {pc, instruction} to decode over a valid/ready handshake. A one-entry skid buffer absorbs decode stalls without losing in-flight reads, and a redirect input handles branches and jumps.

---
 rtl/mips_core_pkg.sv | 32 +++
 rtl/fetch_skid_buffer.sv | 51 +++++
 rtl/instruction_fetch.sv | 76 +++++++
 tb/tb_instruction_fetch.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mips_core_pkg.sv
// Shared MIPS core definitions: datapath width, fetch constants, opcodes and the fetch packet.
package mips_core_pkg;

    localparam int WORD_SIZE = 32;

    typedef logic [WORD_SIZE-1:0] word_t;

    localparam word_t RESET_PC = 32'h0000_0000;
    localparam word_t PC_STEP  = 32'd4;
    localparam word_t NOP_WORD = 32'h0000_0000;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_pkt_t;

    function automatic word_t word_align(input word_t addr);
        return {addr[WORD_SIZE-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {pc, instr} holding register that catches the in-flight read when decode stalls.
module fetch_skid_buffer
    import mips_core_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush_i,
    input  logic       in_valid_i,
    input  fetch_pkt_t in_pkt_i,
    input  logic       out_ready_i,
    output logic       out_valid_o,
    output fetch_pkt_t out_pkt_o,
    output logic       skid_valid_next_o
);

    logic       skid_valid_q;
    logic       skid_valid_d;
    fetch_pkt_t skid_pkt_q;
    fetch_pkt_t skid_pkt_d;

    // Refill from the request path both when the stored entry drains while a read
    // is landing and when a fresh read lands into a stalled, empty buffer.
    always_comb begin
        skid_valid_d = 1'b0;
        skid_pkt_d   = skid_pkt_q;
        if (flush_i) begin
            skid_valid_d = 1'b0;
        end else if (skid_valid_q && !out_ready_i) begin
            skid_valid_d = 1'b1;
        end else if ((skid_valid_q && out_ready_i && in_valid_i) ||
                     (!skid_valid_q && in_valid_i && !out_ready_i)) begin
            skid_valid_d = 1'b1;
            skid_pkt_d   = in_pkt_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_pkt_q   <= '{pc: RESET_PC, instr: NOP_WORD};
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_pkt_q   <= skid_pkt_d;
        end
    end

    assign out_valid_o       = skid_valid_q;
    assign out_pkt_o         = skid_pkt_q;
    assign skid_valid_next_o = skid_valid_d;

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: owns the PC, issues synchronous-read requests and hands {pc, instr} to decode.
module instruction_fetch
    import mips_core_pkg::*;
#(
    parameter word_t RESET_PC_P = RESET_PC,
    parameter word_t PC_STEP_P  = PC_STEP
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fetch_en,
    input  logic                 redirect_valid,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic [WORD_SIZE-1:0] imem_addr,
    input  logic [WORD_SIZE-1:0] imem_instruction,
    output logic                 if_valid,
    input  logic                 if_ready,
    output logic [WORD_SIZE-1:0] if_pc,
    output logic [WORD_SIZE-1:0] if_instruction
);

    word_t      pc_q;
    word_t      pc_d;
    logic       req_valid_q;
    logic       req_valid_d;
    word_t      req_pc_q;
    word_t      req_pc_d;
    logic       issue;
    logic       skid_valid;
    logic       skid_valid_next;
    fetch_pkt_t skid_pkt;

    fetch_skid_buffer u_skid (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush_i           (redirect_valid),
        .in_valid_i        (req_valid_q),
        .in_pkt_i          ('{pc: req_pc_q, instr: imem_instruction}),
        .out_ready_i       (if_ready),
        .out_valid_o       (skid_valid),
        .out_pkt_o         (skid_pkt),
        .skid_valid_next_o (skid_valid_next)
    );

    // A full skid next cycle means decode is backed up; holding issue keeps at most two words in flight.
    always_comb begin
        issue       = fetch_en && !redirect_valid && !skid_valid_next;
        pc_d        = pc_q;
        req_valid_d = 1'b0;
        req_pc_d    = req_pc_q;
        if (redirect_valid) begin
            pc_d = word_align(redirect_pc);
        end else if (issue) begin
            req_valid_d = 1'b1;
            req_pc_d    = pc_q;
            pc_d        = pc_q + PC_STEP_P;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC_P;
            req_valid_q <= 1'b0;
            req_pc_q    <= RESET_PC_P;
        end else begin
            pc_q        <= pc_d;
            req_valid_q <= req_valid_d;
            req_pc_q    <= req_pc_d;
        end
    end

    assign imem_addr      = pc_q;
    assign if_valid       = (skid_valid || req_valid_q) && !redirect_valid;
    assign if_pc          = skid_valid ? skid_pkt.pc    : req_pc_q;
    assign if_instruction = skid_valid ? skid_pkt.instr : imem_instruction;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with an in-order delivery scoreboard and throughput monitor.
module tb_instruction_fetch;
    import mips_core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instruction = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;

    int total = 0;
    int bad = 0;
    int ntx = 0;
    int run_len = 0;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] prog [4] = '{32'h2200_0004, 32'h2220_0006, 32'h0211_9820, 32'h0800_0000};

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fetch_en         (fetch_en),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .imem_addr        (imem_addr),
        .imem_instruction (imem_instruction),
        .if_valid         (if_valid),
        .if_ready         (if_ready),
        .if_pc            (if_pc),
        .if_instruction   (if_instruction)
    );

    function automatic logic [31:0] data_of(input logic [31:0] a);
        case (a)
            32'h0:   data_of = 32'h2200_0004;
            32'h4:   data_of = 32'h2220_0006;
            32'h8:   data_of = 32'h0211_9820;
            32'hC:   data_of = 32'h0800_0000;
            default: data_of = ~a;
        endcase
    endfunction

    always @(posedge clk) imem_instruction <= data_of(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: decode must see one unbroken address stream, restarting only at reset or a redirect target.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_if_valid", {31'b0, if_valid}, 32'd0);
            check("rst_if_pc", if_pc, RESET_PC);
            exp_pc = RESET_PC;
            run_len = 0;
        end else begin
            if (fetch_en && if_ready && !redirect_valid) run_len++;
            else run_len = 0;
            if (redirect_valid) check("redirect_blocks_valid", {31'b0, if_valid}, 32'd0);
            if (run_len >= 2) check("full_throughput", {31'b0, if_valid}, 32'd1);
            if (if_valid && if_ready) begin
                check("seq_pc", if_pc, exp_pc);
                check("seq_instr", if_instruction, data_of(exp_pc));
                $display("tx %0d: pc=%h instr=%h", ntx, if_pc, if_instruction);
                ntx++;
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        fetch_en = 1'b1;
        if_ready = 1'b1;
        repeat (2) tick();
        check("reset_imem_addr", imem_addr, RESET_PC);
        check("reset_if_valid", {31'b0, if_valid}, 32'd0);
        rst_n = 1'b1;
        #1 check("release_no_valid_yet", {31'b0, if_valid}, 32'd0);

        // Program stream, one per cycle
        for (int k = 0; k < 4; k++) begin
            tick();
            check("prog_valid", {31'b0, if_valid}, 32'd1);
            check("prog_pc", if_pc, 32'(k * 4));
            check("prog_instr", if_instruction, prog[k]);
        end

        // Stall three cycles after the first valid
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("stall_first_pc", if_pc, 32'h0);
        if_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_valid", {31'b0, if_valid}, 32'd1);
            check("stall_pc", if_pc, 32'h0);
            check("stall_addr_frozen", imem_addr, 32'h4);
        end
        if_ready = 1'b1;
        tick();
        check("release_pc4", if_pc, 32'h4);
        tick();
        check("release_pc8", if_pc, 32'h8);

        // Redirect to an unaligned target while reads are in flight
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0002;
        #1 check("redir_cycle_valid", {31'b0, if_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        check("redir_bubble", {31'b0, if_valid}, 32'd0);
        tick();
        check("redir_tgt_valid", {31'b0, if_valid}, 32'd1);
        check("redir_tgt_pc", if_pc, 32'h0);
        tick();
        check("redir_next_pc", if_pc, 32'h4);

        // Redirect during a stall with the skid full
        if_ready = 1'b0;
        repeat (2) tick();
        check("skid_full_pc", if_pc, 32'h4);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0040;
        tick();
        redirect_valid = 1'b0;
        if_ready = 1'b1;
        check("skid_flushed", {31'b0, if_valid}, 32'd0);
        tick();
        check("stall_redir_pc", if_pc, 32'h40);
        check("stall_redir_instr", if_instruction, 32'hFFFF_FFBF);
        tick();
        check("stall_redir_next", if_pc, 32'h44);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("wrap_top_pc", if_pc, 32'hFFFF_FFFC);
        tick();
        check("wrap_zero_pc", if_pc, 32'h0);
        check("wrap_zero_instr", if_instruction, 32'h2200_0004);

        // fetch_en low: pending word drains, PC freezes
        fetch_en = 1'b0;
        tick();
        check("fe_off_valid", {31'b0, if_valid}, 32'd0);
        check("fe_off_addr", imem_addr, 32'h4);
        tick();
        check("fe_off_addr_held", imem_addr, 32'h4);
        fetch_en = 1'b1;
        tick();
        check("fe_on_pc", if_pc, 32'h4);
        check("fe_on_valid", {31'b0, if_valid}, 32'd1);

        // Async reset with the skid full
        if_ready = 1'b0;
        repeat (2) tick();
        check("pre_rst_skid_pc", if_pc, 32'h4);
        rst_n = 1'b0;
        #1 check("async_rst_valid", {31'b0, if_valid}, 32'd0);
        check("async_rst_addr", imem_addr, RESET_PC);
        tick();
        rst_n = 1'b1;
        if_ready = 1'b1;
        check("rst_release_idle", {31'b0, if_valid}, 32'd0);
        tick();
        check("rst_restart_pc", if_pc, RESET_PC);
        check("rst_restart_instr", if_instruction, 32'h2200_0004);
        tick();
        check("rst_restart_next", if_pc, 32'h4);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
